reg_file_param: RTL and testbench

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param.sv | 107 ++++++++++
 tb/tb_reg_file_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parameterised register file with two combinational read ports, optional
// write forwarding, optional hardwired zero register and a sequential clear.
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  input  logic                  CLEAR,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  BUSY,
  output logic                  WRITE_DROP
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_drop;
  logic                  w_busy;
  logic                  w_zero_wr;
  logic                  w_wr_en;
  logic                  w_fwd_en;

  assign w_busy     = (r_state == CLEARING);
  assign BUSY       = w_busy;
  assign WRITE_DROP = r_drop;

  // Writes to a hardwired zero register vanish silently, no drop pulse.
  assign w_zero_wr = (ZERO_REG != 0) && (INADDRESS == '0);
  assign w_wr_en   = WRITE && !w_busy && !w_zero_wr;
  assign w_fwd_en  = (BYPASS != 0) && WRITE && !w_busy && !RESET;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (CLEAR) begin
          w_state_nxt = CLEARING;
          w_idx_nxt   = '0;
        end
      end
      CLEARING: begin
        w_idx_nxt = r_idx + 1'b1;
        if (&r_idx) w_state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_drop  <= WRITE && w_busy;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_busy) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[INADDRESS] <= IN;
    end
  end

  always_comb begin
    OUT1 = r_regs[OUT1ADDRESS];
    if (w_fwd_en && (INADDRESS == OUT1ADDRESS))
      OUT1 = IN;
    if ((ZERO_REG != 0) && (OUT1ADDRESS == '0))
      OUT1 = '0;
  end

  always_comb begin
    OUT2 = r_regs[OUT2ADDRESS];
    if (w_fwd_en && (INADDRESS == OUT2ADDRESS))
      OUT2 = IN;
    if ((ZERO_REG != 0) && (OUT2ADDRESS == '0))
      OUT2 = '0;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: default instance plus a
// ZERO_REG=1 instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_reg_file_param;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] IN = '0;
  logic [2:0] INADDRESS = '0;
  logic       WRITE = 1'b0;
  logic [2:0] OUT1ADDRESS = '0;
  logic [2:0] OUT2ADDRESS = '0;
  logic       CLEAR = 1'b0;
  logic [7:0] OUT1, OUT2, z_OUT1, z_OUT2;
  logic       BUSY, WRITE_DROP, z_BUSY, z_DROP;

  typedef struct {
    logic [7:0] e1;
    logic [7:0] e2;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [8];
  int         checks = 0;
  int         errors = 0;

  always #5 CLK = ~CLK;

  reg_file_param dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .CLEAR(CLEAR), .OUT1(OUT1),
    .OUT2(OUT2), .BUSY(BUSY), .WRITE_DROP(WRITE_DROP)
  );

  reg_file_param #(.ZERO_REG(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS),
    .WRITE(WRITE), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .CLEAR(CLEAR), .OUT1(z_OUT1),
    .OUT2(z_OUT2), .BUSY(z_BUSY), .WRITE_DROP(z_DROP)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    INADDRESS = a[2:0];
    IN = d[7:0];
    WRITE = 1'b1;
    tick();
    WRITE = 1'b0;
    mdl[a] = d[7:0];
  endtask

  task automatic test_reset();
    exp_t e;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    checks++;
    if (BUSY !== 1'b0 || WRITE_DROP !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b drop=%b expected 0 0",
               BUSY, WRITE_DROP);
    end
    for (int a = 0; a < 8; a++) sb.push_back('{mdl[a], mdl[7-a]});
    for (int a = 0; a < 8; a++) begin
      tick();
      OUT1ADDRESS = a[2:0];
      OUT2ADDRESS = 3'(7 - a);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
        errors++;
        $display("FAIL reset_read a=%0d: got %0d %0d expected %0d %0d",
                 a, OUT1, OUT2, e.e1, e.e2);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    tick();
    wr(2, 95);
    wr(1, 28);
    sb.push_back('{8'd95, 8'd28});
    OUT1ADDRESS = 3'd2;
    OUT2ADDRESS = 3'd1;
    @(negedge CLK);
    e = sb.pop_front();
    checks++;
    if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
      errors++;
      $display("FAIL write_read: got %0d %0d expected %0d %0d",
               OUT1, OUT2, e.e1, e.e2);
    end
    for (int a = 0; a < 8; a++) sb.push_back('{mdl[a], mdl[7-a]});
    for (int a = 0; a < 8; a++) begin
      tick();
      OUT1ADDRESS = a[2:0];
      OUT2ADDRESS = 3'(7 - a);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
        errors++;
        $display("FAIL write_read_all a=%0d: got %0d %0d expected %0d %0d",
                 a, OUT1, OUT2, e.e1, e.e2);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    tick();
    wr(4, 6);
    OUT1ADDRESS = 3'd4;
    OUT2ADDRESS = 3'd2;
    INADDRESS = 3'd4;
    IN = 8'd15;
    WRITE = 1'b1;
    sb.push_back('{8'd15, 8'd95});
    sb.push_back('{8'd15, 8'd95});
    #1;
    e = sb.pop_front();
    checks++;
    if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
      errors++;
      $display("FAIL bypass_pre: got %0d %0d expected %0d %0d",
               OUT1, OUT2, e.e1, e.e2);
    end
    tick();
    WRITE = 1'b0;
    mdl[4] = 8'd15;
    #1;
    e = sb.pop_front();
    checks++;
    if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
      errors++;
      $display("FAIL bypass_post: got %0d %0d expected %0d %0d",
               OUT1, OUT2, e.e1, e.e2);
    end
  endtask

  task automatic test_back_to_back_clear();
    exp_t e;
    int   n;
    for (int a = 0; a < 8; a++) wr(a, a + 1);
    OUT1ADDRESS = 3'd7;
    OUT2ADDRESS = 3'd0;
    #1;
    checks++;
    if (OUT1 !== 8'd8 || OUT2 !== 8'd1) begin
      errors++;
      $display("FAIL fill: got %0d %0d expected 8 1", OUT1, OUT2);
    end
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    OUT1ADDRESS = 3'd0;
    OUT2ADDRESS = 3'd1;
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      if (n == 1) begin
        checks++;
        if (OUT1 !== 8'd0 || OUT2 !== 8'd2) begin
          errors++;
          $display("FAIL clear_first: got %0d %0d expected 0 2",
                   OUT1, OUT2);
        end
      end
      CLEAR = (n == 3);
      n++;
      tick();
    end
    CLEAR = 1'b0;
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d cycles expected 8", n);
    end
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    for (int a = 0; a < 8; a++) sb.push_back('{mdl[a], mdl[7-a]});
    for (int a = 0; a < 8; a++) begin
      tick();
      OUT1ADDRESS = a[2:0];
      OUT2ADDRESS = 3'(7 - a);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
        errors++;
        $display("FAIL clear_all a=%0d: got %0d %0d expected %0d %0d",
                 a, OUT1, OUT2, e.e1, e.e2);
      end
    end
  endtask

  task automatic test_write_during_clear();
    int n;
    tick();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    OUT1ADDRESS = 3'd1;
    INADDRESS = 3'd1;
    IN = 8'd50;
    WRITE = 1'b1;
    #1;
    checks++;
    if (OUT1 !== 8'd0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL wdc_nofwd: got out1=%0d busy=%b expected 0 1",
               OUT1, BUSY);
    end
    tick();
    WRITE = 1'b0;
    checks++;
    if (WRITE_DROP !== 1'b1 || OUT1 !== 8'd0) begin
      errors++;
      $display("FAIL wdc_drop: got drop=%b out1=%0d expected 1 0",
               WRITE_DROP, OUT1);
    end
    tick();
    checks++;
    if (WRITE_DROP !== 1'b0) begin
      errors++;
      $display("FAIL wdc_drop_end: got %b expected 0", WRITE_DROP);
    end
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n > 10 || OUT1 !== 8'd0) begin
      errors++;
      $display("FAIL wdc_final: got out1=%0d wait=%0d expected 0", OUT1, n);
    end
  endtask

  task automatic test_reset_mid_clear();
    exp_t e;
    wr(3, 33);
    wr(7, 77);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rmc_busy: got %b expected 0", BUSY);
    end
    for (int a = 0; a < 8; a++) sb.push_back('{mdl[a], mdl[7-a]});
    for (int a = 0; a < 8; a++) begin
      tick();
      OUT1ADDRESS = a[2:0];
      OUT2ADDRESS = 3'(7 - a);
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if (OUT1 !== e.e1 || OUT2 !== e.e2 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL rmc_read a=%0d: got %0d %0d busy=%b expected %0d %0d",
                 a, OUT1, OUT2, BUSY, e.e1, e.e2);
      end
    end
    wr(5, 7);
    sb.push_back('{8'd7, 8'd0});
    OUT1ADDRESS = 3'd5;
    OUT2ADDRESS = 3'd3;
    #1;
    e = sb.pop_front();
    checks++;
    if (OUT1 !== e.e1 || OUT2 !== e.e2) begin
      errors++;
      $display("FAIL rmc_write: got %0d %0d expected %0d %0d",
               OUT1, OUT2, e.e1, e.e2);
    end
  endtask

  task automatic test_zero_reg();
    OUT1ADDRESS = 3'd0;
    INADDRESS = 3'd0;
    IN = 8'd9;
    WRITE = 1'b1;
    #1;
    checks++;
    if (z_OUT1 !== 8'd0 || OUT1 !== 8'd9) begin
      errors++;
      $display("FAIL zero_pre: got z=%0d n=%0d expected 0 9", z_OUT1, OUT1);
    end
    tick();
    WRITE = 1'b0;
    checks++;
    if (z_OUT1 !== 8'd0 || z_DROP !== 1'b0 || OUT1 !== 8'd9) begin
      errors++;
      $display("FAIL zero_post: got z=%0d drop=%b n=%0d expected 0 0 9",
               z_OUT1, z_DROP, OUT1);
    end
    tick();
    checks++;
    if (z_DROP !== 1'b0 || z_OUT1 !== 8'd0) begin
      errors++;
      $display("FAIL zero_drop: got drop=%b z=%0d expected 0 0",
               z_DROP, z_OUT1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back_clear();
    test_write_during_clear();
    test_reset_mid_clear();
    test_zero_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
